// File: rtl/systolic_feeder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_feeder_if                                              |
// | Brief    : Host write/start bus and array-edge outputs of systolic_feeder. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface systolic_feeder_if #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 3
);
  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_row;
  logic [AW-1:0]   wr_col;
  logic [DW-1:0]   wr_data;
  logic            start;
  logic [N*DW-1:0] a_edge;
  logic [N*DW-1:0] b_edge;
  logic            pe_clr;
  logic            busy;
  logic            done;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  a_edge, b_edge, pe_clr, busy, done
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output a_edge, b_edge, pe_clr, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : systolic_feeder                                                 |
// | Brief    : Buffers NxN A/B operands and streams them diagonally skewed     |
// |            into a systolic MAC array (clear, feed, flush, done).           |
// | Option   : SYSTOLIC_FEEDER_B_TRANSPOSE_EN stores B writes transposed.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module systolic_feeder #(
  parameter int N  = 4,
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic               clk,
  input  logic               rst,
  systolic_feeder_if.slave   bus
);

  localparam int            c_DEPTH      = 1 << AW;
  localparam logic [AW:0]   c_N          = (AW+1)'(N);
  localparam logic [AW:0]   c_FEED_LAST  = (AW+1)'(2*N-2);
  localparam logic [AW:0]   c_FLUSH_LAST = (AW+1)'(N-2);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CLR   = 3'd1;
  localparam logic [2:0] c_FEED  = 3'd2;
  localparam logic [2:0] c_FLUSH = 3'd3;
  localparam logic [2:0] c_DONE  = 3'd4;

  logic [2:0]      r_state, w_state_nxt;
  logic [AW:0]     r_t, w_t_nxt;
  logic [DW-1:0]   r_a [c_DEPTH][c_DEPTH];
  logic [DW-1:0]   r_b [c_DEPTH][c_DEPTH];
  logic [N*DW-1:0] w_a_nxt, w_b_nxt, r_a_edge, r_b_edge;
  logic            w_clr_nxt, w_busy_nxt, w_done_nxt;
  logic            r_pe_clr, r_busy, r_done;
  logic            w_wr_ok;

  assign w_wr_ok = bus.wr_en && (r_state == c_IDLE)
                 && ({1'b0, bus.wr_row} < c_N) && ({1'b0, bus.wr_col} < c_N);

  // Operand buffers; a write in the same cycle as start lands before the run reads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < c_DEPTH; r++) begin
        for (int c = 0; c < c_DEPTH; c++) begin
          r_a[r][c] <= '0;
          r_b[r][c] <= '0;
        end
      end
    end else if (w_wr_ok) begin
      if (!bus.wr_sel) begin
        r_a[bus.wr_row][bus.wr_col] <= bus.wr_data;
      end else begin
`ifdef SYSTOLIC_FEEDER_B_TRANSPOSE_EN
        r_b[bus.wr_col][bus.wr_row] <= bus.wr_data;
`else
        r_b[bus.wr_row][bus.wr_col] <= bus.wr_data;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_t     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_t     <= w_t_nxt;
    end
  end

  // r_t counts feed steps in FEED and is reused as the flush counter in FLUSH.
  always_comb begin
    w_state_nxt = r_state;
    w_t_nxt     = r_t;
    case (r_state)
      c_IDLE: begin
        if (bus.start) w_state_nxt = c_CLR;
      end
      c_CLR: begin
        w_state_nxt = c_FEED;
        w_t_nxt     = '0;
      end
      c_FEED: begin
        if (r_t == c_FEED_LAST) begin
          w_state_nxt = c_FLUSH;
          w_t_nxt     = '0;
        end else begin
          w_t_nxt = r_t + (AW+1)'(1);
        end
      end
      c_FLUSH: begin
        if (r_t == c_FLUSH_LAST) begin
          w_state_nxt = c_DONE;
          w_t_nxt     = '0;
        end else begin
          w_t_nxt = r_t + (AW+1)'(1);
        end
      end
      c_DONE: begin
        w_state_nxt = c_IDLE;
        w_t_nxt     = '0;
      end
      default: begin
        w_state_nxt = c_IDLE;
        w_t_nxt     = '0;
      end
    endcase
  end

  always_comb begin
    w_clr_nxt  = (w_state_nxt == c_CLR);
    w_busy_nxt = (w_state_nxt == c_CLR) || (w_state_nxt == c_FEED) || (w_state_nxt == c_FLUSH);
    w_done_nxt = (w_state_nxt == c_DONE);
  end

  // Lane i carries A row i / B column i, delayed by i steps.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    logic [AW:0] w_k;
    logic        w_hit;
    assign w_k   = w_t_nxt - (AW+1)'(gi);
    assign w_hit = (w_state_nxt == c_FEED) && (w_t_nxt >= (AW+1)'(gi)) && (w_k < c_N);
    assign w_a_nxt[gi*DW +: DW] = w_hit ? r_a[gi][w_k[AW-1:0]] : '0;
    assign w_b_nxt[gi*DW +: DW] = w_hit ? r_b[w_k[AW-1:0]][gi] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a_edge <= '0;
      r_b_edge <= '0;
      r_pe_clr <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_a_edge <= w_a_nxt;
      r_b_edge <= w_b_nxt;
      r_pe_clr <= w_clr_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.a_edge = r_a_edge;
  assign bus.b_edge = r_b_edge;
  assign bus.pe_clr = r_pe_clr;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_systolic_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_systolic_feeder                                              |
// | Brief    : Self-checking bench for systolic_feeder against a run-schedule  |
// |            model.                                                          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_systolic_feeder;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  systolic_feeder_if #(.N(N), .DW(DW), .AW(AW)) bus ();
  systolic_feeder #(.N(N), .DW(DW), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct packed {
    logic [N*DW-1:0] a;
    logic [N*DW-1:0] b;
    logic            clr;
    logic            busy;
    logic            done;
  } exp_t;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   chk_en      = 1'b0;
  int   ma [N][N];
  int   mb [N][N];
  exp_t q[$];
  exp_t cur;
  bit   cur_idle;

  // Whole run as a list of per-cycle outputs: clear, skewed feed, flush, done.
  function automatic void build_run();
    exp_t e;
    e = '0; e.clr = 1'b1; e.busy = 1'b1;
    q.push_back(e);
    for (int t = 0; t < 2*N-1; t++) begin
      e = '0; e.busy = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (t - i >= 0 && t - i < N) begin
          e.a[i*DW +: DW] = DW'(ma[i][t-i]);
          e.b[i*DW +: DW] = DW'(mb[t-i][i]);
        end
      end
      q.push_back(e);
    end
    for (int f = 0; f < N-1; f++) begin
      e = '0; e.busy = 1'b1;
      q.push_back(e);
    end
    e = '0; e.done = 1'b1;
    q.push_back(e);
  endfunction

  initial begin
    cur = '0;
    cur_idle = 1'b1;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            ma[r][c] = 0;
            mb[r][c] = 0;
          end
        q.delete();
        cur = '0;
        cur_idle = 1'b1;
      end else begin
        if (cur_idle) begin
          if (bus.wr_en && int'(bus.wr_row) < N && int'(bus.wr_col) < N) begin
            if (!bus.wr_sel) ma[bus.wr_row][bus.wr_col] = int'(bus.wr_data);
`ifdef SYSTOLIC_FEEDER_B_TRANSPOSE_EN
            else mb[bus.wr_col][bus.wr_row] = int'(bus.wr_data);
`else
            else mb[bus.wr_row][bus.wr_col] = int'(bus.wr_data);
`endif
          end
          if (bus.start) build_run();
        end
        if (q.size() > 0) begin
          cur = q.pop_front();
          cur_idle = 1'b0;
        end else begin
          cur = '0;
          cur_idle = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        vectors++;
        if ({bus.a_edge, bus.b_edge, bus.pe_clr, bus.busy, bus.done} !== cur) begin
          miscompares++;
          $display("FAIL cycle @%0t: got a=%h b=%h clr=%b busy=%b done=%b, want a=%h b=%h clr=%b busy=%b done=%b",
                   $time, bus.a_edge, bus.b_edge, bus.pe_clr, bus.busy, bus.done,
                   cur.a, cur.b, cur.clr, cur.busy, cur.done);
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int s, input int r, input int c, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = 1'(s);
    bus.wr_row  = AW'(r);
    bus.wr_col  = AW'(c);
    bus.wr_data = DW'(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    int n, dcount, nw, nc;
    logic [N*DW-1:0] or_edges;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.start = 1'b0;

    #2 rst = 1'b0;
    #1;
    check("rst_a_edge", 64'(bus.a_edge), 64'h0);
    check("rst_b_edge", 64'(bus.b_edge), 64'h0);
    check("rst_flags", {61'h0, bus.pe_clr, bus.busy, bus.done}, 64'h0);
    #9 rst = 1'b1;
    chk_en = 1'b1;
    tick();

    // Basic skew with the 2x2 example in the top-left corner.
    wr(0, 0, 0, 1); wr(0, 0, 1, 2); wr(0, 1, 0, 3); wr(0, 1, 1, 4);
`ifdef SYSTOLIC_FEEDER_B_TRANSPOSE_EN
    wr(1, 0, 0, 5); wr(1, 0, 1, 7); wr(1, 1, 0, 6); wr(1, 1, 1, 8);
`else
    wr(1, 0, 0, 5); wr(1, 0, 1, 6); wr(1, 1, 0, 7); wr(1, 1, 1, 8);
`endif
    pulse_start();
    check("clr_cycle", {62'h0, bus.pe_clr, bus.busy}, 64'h3);
    tick();
    check("t0_a", 64'(bus.a_edge), 64'h00000001);
    check("t0_b", 64'(bus.b_edge), 64'h00000005);
    tick();
    check("t1_a", 64'(bus.a_edge), 64'h00000302);
    check("t1_b", 64'(bus.b_edge), 64'h00000607);
    tick();
    check("t2_a", 64'(bus.a_edge), 64'h00000400);
    check("t2_b", 64'(bus.b_edge), 64'h00000800);
    n = 4;
    while (!bus.done && n < 100) begin
      tick();
      n++;
    end
    check("done_latency", 64'(n), 64'(3*N));
    check("done_not_busy", 64'(bus.busy), 64'h0);
    tick();

    // Write and start during a run are both ignored.
    pulse_start();
    wr(0, 0, 0, 9);
    pulse_start();
    dcount = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.done) dcount++;
    end
    check("single_done", 64'(dcount), 64'h1);
    pulse_start();
    tick();
    check("a00_kept", 64'(bus.a_edge[DW-1:0]), 64'h1);
    repeat (3*N) tick();

    // Write and start in the same idle cycle.
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = AW'(1); bus.wr_col = AW'(1);
    bus.wr_data = DW'(8'hFF); bus.start = 1'b1;
    tick();
    bus.wr_en = 1'b0; bus.start = 1'b0;
    repeat (3) tick();
    check("same_cycle_t2_a", 64'(bus.a_edge), 64'h0000FF00);
    repeat (3*N) tick();

    // Reset in the middle of FEED, then a run on cleared buffers.
    pulse_start();
    repeat (4) tick();
    check("busy_before_rst", 64'(bus.busy), 64'h1);
    #2 rst = 1'b0;
    #1;
    check("midrst_edges", 64'(bus.a_edge | bus.b_edge), 64'h0);
    check("midrst_flags", {61'h0, bus.pe_clr, bus.busy, bus.done}, 64'h0);
    #3 rst = 1'b1;
    tick();
    pulse_start();
    or_edges = '0;
    dcount = 0;
    for (int k = 0; k < 3*N+2; k++) begin
      or_edges |= bus.a_edge | bus.b_edge;
      if (bus.done) dcount++;
      tick();
    end
    check("cleared_run_edges", 64'(or_edges), 64'h0);
    check("cleared_run_done", 64'(dcount), 64'h1);

    // Randomized traffic, including out-of-range indices and stray starts/writes.
    for (int r = 0; r < 40; r++) begin
      nw = $urandom_range(0, 5);
      for (int w = 0; w < nw; w++)
        wr(int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      bus.wr_en   = 1'($urandom_range(0, 1));
      bus.wr_sel  = 1'($urandom_range(0, 1));
      bus.wr_row  = AW'($urandom_range(0, 7));
      bus.wr_col  = AW'($urandom_range(0, 7));
      bus.wr_data = DW'($urandom_range(0, 255));
      bus.start   = 1'b1;
      tick();
      nc = $urandom_range(0, 3*N+3);
      for (int c = 0; c < nc; c++) begin
        bus.wr_en   = 1'($urandom_range(0, 1));
        bus.wr_sel  = 1'($urandom_range(0, 1));
        bus.wr_row  = AW'($urandom_range(0, 7));
        bus.wr_col  = AW'($urandom_range(0, 7));
        bus.wr_data = DW'($urandom_range(0, 255));
        bus.start   = ($urandom_range(0, 5) == 0);
        tick();
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
    end
    repeat (3*N+2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
